// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-port bundle for mem_access_ctrl.
// ReqValid/ReqReady: a request transfers on a rising edge where both are 1; RespValid is a one-cycle pulse with no backpressure.
interface mem_access_ctrl_if #(
  parameter int AddressSize = 13
);
  logic                   ReqValid;
  logic                   ReqReady;
  logic                   ReqWrite;
  logic [1:0]             ReqSize;
  logic                   ReqSigned;
  logic [31:0]            ReqAddr;
  logic [31:0]            ReqWData;
  logic                   RespValid;
  logic [31:0]            RespData;
  logic                   AddrError;
  logic                   MemWriteEn;
  logic                   MemReadEn;
  logic [AddressSize-1:0] MemAddress;
  logic [31:0]            MemWriteData;
  logic [31:0]            MemReadData;

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemReadData,
    output ReqReady, RespValid, RespData, AddrError,
           MemWriteEn, MemReadEn, MemAddress, MemWriteData
  );

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemReadData,
    input  ReqReady, RespValid, RespData, AddrError,
           MemWriteEn, MemReadEn, MemAddress, MemWriteData
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store initiator for a word-addressed synchronous memory.
// Sub-word stores are read-modify-write; loads are extended; misaligned requests are rejected.
module mem_access_ctrl #(
  parameter int AddressSize = 13,
  parameter int WordSize    = 32
) (
  input  logic               Clock,
  input  logic               nReset,
  mem_access_ctrl_if.slave   bus,
  output logic [2:0]         debug_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    LDRESP = 3'd2,
    MERGE  = 3'd3,
    WR     = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t                 state;
  logic                   write_q;
  logic [1:0]             size_q;
  logic                   signed_q;
  logic [1:0]             off_q;
  logic [WordSize-1:0]    wdata_q;
  logic                   ready_q;
  logic                   resp_valid_q;
  logic                   addr_err_q;
  logic                   rd_en_q;
  logic                   wr_en_q;
  logic [AddressSize-1:0] mem_addr_q;

  logic                   req_err;
  logic [7:0]             lane_byte;
  logic [15:0]            lane_half;
  logic [31:0]            load_val;
  logic [31:0]            merged;

  always_comb begin
    req_err = 1'b0;
    case (bus.ReqSize)
      2'b01:   req_err = bus.ReqAddr[0];
      2'b10:   req_err = (bus.ReqAddr[1:0] != 2'b00);
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state        <= IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ReqValid && ready_q) begin
            write_q  <= bus.ReqWrite;
            size_q   <= bus.ReqSize;
            signed_q <= bus.ReqSigned;
            off_q    <= bus.ReqAddr[1:0];
            wdata_q  <= bus.ReqWData;
            ready_q  <= 1'b0;
            if (req_err) begin
              state        <= ERR;
              resp_valid_q <= 1'b1;
              addr_err_q   <= 1'b1;
            end else if (!bus.ReqWrite || bus.ReqSize != 2'b10) begin
              state      <= RD;
              rd_en_q    <= 1'b1;
              mem_addr_q <= bus.ReqAddr[AddressSize+1:2];
            end else begin
              state      <= WR;
              wr_en_q    <= 1'b1;
              mem_addr_q <= bus.ReqAddr[AddressSize+1:2];
            end
          end
        end
        RD: begin
          rd_en_q <= 1'b0;
          if (write_q) begin
            // Address stays on the bus so the merged word lands where it was read.
            state   <= MERGE;
            wr_en_q <= 1'b1;
          end else begin
            state        <= LDRESP;
            resp_valid_q <= 1'b1;
            mem_addr_q   <= '0;
          end
        end
        MERGE, WR: begin
          state        <= DONE;
          wr_en_q      <= 1'b0;
          mem_addr_q   <= '0;
          resp_valid_q <= 1'b1;
        end
        LDRESP, DONE, ERR: begin
          state        <= IDLE;
          resp_valid_q <= 1'b0;
          addr_err_q   <= 1'b0;
          ready_q      <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          addr_err_q   <= 1'b0;
          rd_en_q      <= 1'b0;
          wr_en_q      <= 1'b0;
          mem_addr_q   <= '0;
        end
      endcase
    end
  end

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    lane_byte = 8'h00;
    case (off_q)
      2'd0:    lane_byte = bus.MemReadData[31:24];
      2'd1:    lane_byte = bus.MemReadData[23:16];
      2'd2:    lane_byte = bus.MemReadData[15:8];
      default: lane_byte = bus.MemReadData[7:0];
    endcase
    lane_half = off_q[1] ? bus.MemReadData[15:0] : bus.MemReadData[31:16];
  end

  always_comb begin
    load_val = bus.MemReadData;
    case (size_q)
      2'b00:   load_val = signed_q ? {{24{lane_byte[7]}}, lane_byte} : {24'h000000, lane_byte};
      2'b01:   load_val = signed_q ? {{16{lane_half[15]}}, lane_half} : {16'h0000, lane_half};
      default: load_val = bus.MemReadData;
    endcase
  end

  always_comb begin
    merged = bus.MemReadData;
    if (size_q == 2'b00) begin
      case (off_q)
        2'd0:    merged[31:24] = wdata_q[7:0];
        2'd1:    merged[23:16] = wdata_q[7:0];
        2'd2:    merged[15:8]  = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[15:0] = wdata_q[15:0];
    end else begin
      merged[31:16] = wdata_q[15:0];
    end
  end

  // Read data arrives the cycle after ReadEn, so the data paths are decoded from state.
  assign bus.RespData     = (state == LDRESP) ? load_val : 32'h0;
  assign bus.MemWriteData = (state == MERGE) ? merged :
                            (state == WR)    ? wdata_q : 32'h0;
  assign bus.ReqReady     = ready_q;
  assign bus.RespValid    = resp_valid_q;
  assign bus.AddrError    = addr_err_q;
  assign bus.MemReadEn    = rd_en_q;
  assign bus.MemWriteEn   = wr_en_q;
  assign bus.MemAddress   = mem_addr_q;
  assign debug_state      = state;

endmodule
